// File: rtl/pipe_stage_reg_if.sv
// Bundle between two pipeline stages: upstream slot, control, registered slot and hazard status.
interface pipe_stage_reg_if #(
  parameter int unsigned PAYLOAD_W = 128,
  parameter int unsigned TNEW_W    = 4,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CNT_W     = 16
);
  logic                 stall;
  logic                 flush;
  logic                 in_valid;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [TNEW_W-1:0]    in_tnew;
  logic [REG_W-1:0]     in_wreg;
  logic [DATA_W-1:0]    in_wdata;
  logic                 out_valid;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [TNEW_W-1:0]    out_tnew;
  logic [REG_W-1:0]     out_wreg;
  logic [DATA_W-1:0]    out_wdata;
  logic                 fwd_ok;
  logic [CNT_W-1:0]     stall_cnt;

  modport master (
    output stall, flush, in_valid, in_payload, in_tnew, in_wreg, in_wdata,
    input  out_valid, out_payload, out_tnew, out_wreg, out_wdata, fwd_ok, stall_cnt
  );

  modport slave (
    input  stall, flush, in_valid, in_payload, in_tnew, in_wreg, in_wdata,
    output out_valid, out_payload, out_tnew, out_wreg, out_wdata, fwd_ok, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic MIPS inter-stage latch: payload plus hazard bookkeeping with hold, bubble
// insertion, Tnew countdown, registered forward-ready flag and saturating stall counter.
module pipe_stage_reg #(
  parameter int unsigned PAYLOAD_W   = 128,
  parameter int unsigned TNEW_W      = 4,
  parameter int unsigned REG_W       = 5,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CNT_W       = 16,
  parameter bit          DEC_ON_LOAD = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  pipe_stage_reg_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                 valid_q,   valid_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [TNEW_W-1:0]    tnew_q,    tnew_d;
  logic [REG_W-1:0]     wreg_q,    wreg_d;
  logic [DATA_W-1:0]    wdata_q,   wdata_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic                 fwd_q,     fwd_d;

  // Next-state selection: flush > stall > load.
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    tnew_d    = tnew_q;
    wreg_d    = wreg_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    if (bus.flush) begin
      valid_d   = 1'b0;
      payload_d = '0;
      tnew_d    = '0;
      wreg_d    = '0;
      wdata_d   = '0;
    end else if (bus.stall) begin
      tnew_d = (tnew_q == '0) ? '0 : tnew_q - TNEW_W'(1);
      cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end else begin
      valid_d   = bus.in_valid;
      payload_d = bus.in_payload;
      wdata_d   = bus.in_wdata;
      if (bus.in_valid) begin
        wreg_d = bus.in_wreg;
        if (DEC_ON_LOAD)
          tnew_d = (bus.in_tnew == '0) ? '0 : bus.in_tnew - TNEW_W'(1);
        else
          tnew_d = bus.in_tnew;
      end else begin
        wreg_d = '0;
        tnew_d = '0;
      end
    end
    // Computed from next state so the flag is a flop that always matches the slot contents.
    fwd_d = valid_d & (wreg_d != '0) & (tnew_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      tnew_q    <= '0;
      wreg_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      fwd_q     <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      tnew_q    <= tnew_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      fwd_q     <= fwd_d;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_payload = payload_q;
  assign bus.out_tnew    = tnew_q;
  assign bus.out_wreg    = wreg_q;
  assign bus.out_wdata   = wdata_q;
  assign bus.fwd_ok      = fwd_q;
  assign bus.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives two latch instances (DEC_ON_LOAD=1/CNT_W=16 and DEC_ON_LOAD=0/CNT_W=3) with the
// same stimulus and compares them against a behavioural slot model.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.PAYLOAD_W(128), .TNEW_W(4), .REG_W(5), .DATA_W(32), .CNT_W(16)) bus_a ();
  pipe_stage_reg_if #(.PAYLOAD_W(128), .TNEW_W(4), .REG_W(5), .DATA_W(32), .CNT_W(3))  bus_b ();

  pipe_stage_reg #(.PAYLOAD_W(128), .TNEW_W(4), .REG_W(5), .DATA_W(32), .CNT_W(16), .DEC_ON_LOAD(1'b1))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  pipe_stage_reg #(.PAYLOAD_W(128), .TNEW_W(4), .REG_W(5), .DATA_W(32), .CNT_W(3), .DEC_ON_LOAD(1'b0))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  int n_assert = 0;
  int n_fail   = 0;

  // Stimulus shared by both instances
  logic         s_stall, s_flush, s_valid;
  logic [127:0] s_payload;
  int           s_tnew, s_wreg;
  logic [31:0]  s_wdata;

  // Reference slot per instance
  int           m_valid[2], m_tnew[2], m_wreg[2];
  longint       m_cnt[2];
  logic [127:0] m_payload[2];
  logic [31:0]  m_wdata[2];
  int           m_dec[2]  = '{1, 0};
  longint       m_cmax[2] = '{65535, 7};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 0; m_tnew[k] = 0; m_wreg[k] = 0; m_cnt[k] = 0;
      m_payload[k] = '0; m_wdata[k] = '0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (s_flush) begin
        m_valid[k] = 0; m_payload[k] = '0; m_tnew[k] = 0; m_wreg[k] = 0; m_wdata[k] = '0;
      end else if (s_stall) begin
        if (m_tnew[k] > 0) m_tnew[k] = m_tnew[k] - 1;
        if (m_cnt[k] < m_cmax[k]) m_cnt[k] = m_cnt[k] + 1;
      end else begin
        m_valid[k]   = s_valid ? 1 : 0;
        m_payload[k] = s_payload;
        m_wdata[k]   = s_wdata;
        if (s_valid) begin
          m_wreg[k] = s_wreg;
          m_tnew[k] = (m_dec[k] != 0) ? ((s_tnew > 0) ? s_tnew - 1 : 0) : s_tnew;
        end else begin
          m_wreg[k] = 0;
          m_tnew[k] = 0;
        end
      end
    end
  endtask

  function automatic logic exp_fwd(input int k);
    return (m_valid[k] != 0) && (m_wreg[k] != 0) && (m_tnew[k] == 0);
  endfunction

  task automatic check_all(input string ctx);
    chk({ctx, " a.valid"},   128'(bus_a.out_valid),   128'(m_valid[0]));
    chk({ctx, " a.payload"}, bus_a.out_payload,       m_payload[0]);
    chk({ctx, " a.tnew"},    128'(bus_a.out_tnew),    128'(m_tnew[0]));
    chk({ctx, " a.wreg"},    128'(bus_a.out_wreg),    128'(m_wreg[0]));
    chk({ctx, " a.wdata"},   128'(bus_a.out_wdata),   128'(m_wdata[0]));
    chk({ctx, " a.fwd_ok"},  128'(bus_a.fwd_ok),      128'(exp_fwd(0)));
    chk({ctx, " a.cnt"},     128'(bus_a.stall_cnt),   128'(m_cnt[0]));
    chk({ctx, " b.valid"},   128'(bus_b.out_valid),   128'(m_valid[1]));
    chk({ctx, " b.payload"}, bus_b.out_payload,       m_payload[1]);
    chk({ctx, " b.tnew"},    128'(bus_b.out_tnew),    128'(m_tnew[1]));
    chk({ctx, " b.wreg"},    128'(bus_b.out_wreg),    128'(m_wreg[1]));
    chk({ctx, " b.wdata"},   128'(bus_b.out_wdata),   128'(m_wdata[1]));
    chk({ctx, " b.fwd_ok"},  128'(bus_b.fwd_ok),      128'(exp_fwd(1)));
    chk({ctx, " b.cnt"},     128'(bus_b.stall_cnt),   128'(m_cnt[1]));
  endtask

  task automatic drive();
    bus_a.stall = s_stall;  bus_b.stall = s_stall;
    bus_a.flush = s_flush;  bus_b.flush = s_flush;
    bus_a.in_valid = s_valid; bus_b.in_valid = s_valid;
    bus_a.in_payload = s_payload; bus_b.in_payload = s_payload;
    bus_a.in_tnew = 4'(s_tnew); bus_b.in_tnew = 4'(s_tnew);
    bus_a.in_wreg = 5'(s_wreg); bus_b.in_wreg = 5'(s_wreg);
    bus_a.in_wdata = s_wdata; bus_b.in_wdata = s_wdata;
  endtask

  // Apply stimulus, take one rising edge, then compare 1 time unit later.
  task automatic cyc(input string ctx);
    drive();
    @(posedge clk);
    model_step();
    #1;
    check_all(ctx);
  endtask

  task automatic set_in(input logic st, input logic fl, input logic v, input logic [127:0] p,
                        input int t, input int w, input logic [31:0] d);
    s_stall = st; s_flush = fl; s_valid = v; s_payload = p; s_tnew = t; s_wreg = w; s_wdata = d;
  endtask

  task automatic async_reset(input string ctx);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all(ctx);
    #2 reset = 1'b0;
  endtask

  initial begin
    // Reset with live inputs
    set_in(1'b0, 1'b0, 1'b1, {4{32'hDEADBEEF}}, 5, 9, 32'hCAFEF00D);
    drive();
    #12;
    model_reset();
    check_all("reset_hold");
    @(negedge clk);
    reset = 1'b0;
    cyc("first_load");
    async_reset("reset_async");

    // Load then countdown under stall
    set_in(1'b0, 1'b0, 1'b1, 128'h1111, 2, 5, 32'h1234);
    cyc("load_t2");
    chk("plan a.tnew=1", 128'(bus_a.out_tnew), 128'd1);
    chk("plan a.fwd=0",  128'(bus_a.fwd_ok),   128'd0);
    s_stall = 1'b1;
    cyc("stall1");
    chk("plan a.tnew=0",   128'(bus_a.out_tnew),  128'd0);
    chk("plan a.fwd=1",    128'(bus_a.fwd_ok),    128'd1);
    chk("plan a.wdata",    128'(bus_a.out_wdata), 128'h1234);
    for (int i = 0; i < 3; i++) cyc("stall_more");
    chk("plan a.cnt=4",    128'(bus_a.stall_cnt), 128'd4);

    // Flush wins over stall, counter untouched
    s_flush = 1'b1;
    cyc("flush_stall");
    chk("plan flush valid", 128'(bus_a.out_valid), 128'd0);
    chk("plan flush cnt",   128'(bus_a.stall_cnt), 128'd4);

    // Invalid load clears wreg/tnew but passes payload
    set_in(1'b0, 1'b0, 1'b0, 128'hABCD_0000_0000_0000_0000_0000_0000_5555, 3, 7, 32'h77);
    cyc("invalid_load");
    chk("plan inv wreg",    128'(bus_a.out_wreg),  128'd0);
    chk("plan inv payload", bus_a.out_payload,     128'hABCD_0000_0000_0000_0000_0000_0000_5555);

    // Counter saturation on the 3-bit instance
    s_stall = 1'b1;
    for (int i = 0; i < 10; i++) cyc("sat_stall");
    chk("plan b.cnt=7",  128'(bus_b.stall_cnt), 128'd7);
    chk("plan a.cnt=14", 128'(bus_a.stall_cnt), 128'd14);

    // Tnew=0 load must not wrap
    set_in(1'b0, 1'b0, 1'b1, 128'h2, 0, 4, 32'h9);
    cyc("load_t0");
    chk("plan a.tnew no wrap", 128'(bus_a.out_tnew), 128'd0);

    // No decrement on load for instance b
    set_in(1'b0, 1'b0, 1'b1, 128'h3, 1, 3, 32'h33);
    cyc("nodec_load");
    chk("plan b.tnew=1", 128'(bus_b.out_tnew), 128'd1);
    chk("plan b.fwd=0",  128'(bus_b.fwd_ok),   128'd0);
    s_stall = 1'b1;
    cyc("nodec_stall");
    chk("plan b.tnew=0", 128'(bus_b.out_tnew), 128'd0);
    chk("plan b.fwd=1",  128'(bus_b.fwd_ok),   128'd1);

    // Reset mid-stall clears the counter
    async_reset("reset_midstall");

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
             {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 15)),
             int'($urandom_range(0, 31)), $urandom);
      cyc("rand");
      if ($urandom_range(0, 63) == 0) async_reset("rand_reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core; it generalises the E→M stage latch so any of the D/E, E/M or M/W boundaries can use it. It registers an opaque instruction payload together with hazard bookkeeping (valid, Tnew, destination register, forward data). It supports hold (stall), bubble insertion (flush) and per-cycle Tnew countdown. It produces a registered forwarding-ready flag and a saturating stall-cycle counter for the hazard unit and debug.

## Interface
Parameters:
- PAYLOAD_W, 128, width of packed payload (IR, PC, PC8, rt, AO, ctrl bits); opaque to this block
- TNEW_W, 4, width of Tnew field
- REG_W, 5, destination register index width
- DATA_W, 32, forward data width
- CNT_W, 16, stall counter width
- DEC_ON_LOAD, 1, 1: captured Tnew = in_tnew−1 (saturating at 0); 0: captured Tnew = in_tnew

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- stall  in  1  hold current contents
- flush  in  1  load a bubble
- in_valid  in  1  upstream slot holds a real instruction
- in_payload  in  PAYLOAD_W  upstream payload
- in_tnew  in  TNEW_W  cycles until upstream result is available
- in_wreg  in  REG_W  upstream destination register (0 = none)
- in_wdata  in  DATA_W  upstream result value (meaningful once Tnew reaches 0)
- out_valid  out  1  registered valid
- out_payload  out  PAYLOAD_W  registered payload
- out_tnew  out  TNEW_W  registered Tnew
- out_wreg  out  REG_W  registered destination
- out_wdata  out  DATA_W  registered result value
- fwd_ok  out  1  out_valid & (out_wreg≠0) & (out_tnew==0)
- stall_cnt  out  CNT_W  count of cycles with stall=1 & flush=0, saturating

## Operation
- Update priority each rising edge: reset (async) > flush > stall > load.
- Reset: every output and register goes to 0 immediately, independent of clk. out_payload = 0 encodes MIPS nop (sll $0,$0,0).
- Flush: out_valid←0, out_payload←0, out_tnew←0, out_wreg←0, out_wdata←0. stall_cnt is unchanged. Flush overrides a simultaneous stall.
- Stall (flush=0): payload, valid, wreg and wdata hold. out_tnew←max(out_tnew−1,0), because time advances while the instruction waits. stall_cnt←stall_cnt+1, saturating at 2^CNT_W−1 with no wrap.
- Load (stall=0, flush=0):
  - out_valid←in_valid and out_payload←in_payload.
  - If in_valid=0, out_wreg←0 and out_tnew←0. Otherwise out_wreg←in_wreg, and out_tnew←in_tnew−1 (saturating at 0) when DEC_ON_LOAD=1, else in_tnew.
  - out_wdata←in_wdata.
- Tnew arithmetic is unsigned TNEW_W bits. A decrement at 0 stays 0 and never wraps to all-ones.
- fwd_ok is a combinational function of the registered outputs only. It has no path from inputs.
- An invalid slot never forwards: out_wreg is forced to 0 whenever the slot is loaded invalid or flushed.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- No combinational input→output paths, so the block is safe to chain back-to-back.
- Reset deassertion is taken synchronously by the next edge. The first load occurs on the first edge with reset=0.
- Reset asserted mid-stall or mid-countdown: everything clears at once, including stall_cnt.
- stall held for K cycles: contents are frozen, out_tnew reaches 0 after at most its value in cycles, and stall_cnt advances by K (saturating).
- Stall released: the load happens on the same edge at which stall is sampled low.

## Test plan
- Reset: drive in_* nonzero, assert reset asynchronously between edges → all outputs 0 before the next edge; stall_cnt=0.
- Load/countdown (DEC_ON_LOAD=1): load in_valid=1, in_tnew=2, in_wreg=5, in_wdata=0x1234 → next cycle out_tnew=1, fwd_ok=0. Stall 1 cycle → out_tnew=0, fwd_ok=1, out_wdata=0x1234. Stall 3 more cycles → out_tnew stays 0 and stall_cnt=4.
- Flush vs stall: with a valid entry held, assert stall=1 and flush=1 together → out_valid=0, out_payload=0, out_wreg=0, fwd_ok=0, stall_cnt unchanged.
- Invalid load: in_valid=0, in_wreg=7, in_tnew=3 → out_wreg=0, out_tnew=0, fwd_ok=0, out_payload=in_payload.
- Saturation: CNT_W=3, stall for 10 cycles → stall_cnt=7. Load in_tnew=0 with DEC_ON_LOAD=1 → out_tnew=0, not 0xF.
- DEC_ON_LOAD=0: load in_tnew=1, in_wreg=3 → out_tnew=1, fwd_ok=0; one stall cycle → out_tnew=0, fwd_ok=1.
